// File: rtl/pipelinestages_pkg.sv
// Shared pipeline-stage definitions for the RISC pipeline.
// Holds the packed stage structs carried between stages, their widths
// for sizing elastic stage payloads, and the legal elastic buffer depths.
package pipelinestages_pkg;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } if_id_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] rs1_val;
        logic [31:0] rs2_val;
        logic [31:0] imm;
        logic [4:0]  rd;
        logic [3:0]  alu_op;
        logic        alu_src;
        logic        reg_write;
        logic        mem_read;
        logic        mem_write;
        logic        branch;
    } id_ex_t;

    typedef struct packed {
        logic [31:0] alu_result;
        logic [31:0] store_data;
        logic [4:0]  rd;
        logic        reg_write;
        logic        mem_read;
        logic        mem_write;
    } ex_mem_t;

    typedef struct packed {
        logic [31:0] wb_data;
        logic [4:0]  rd;
        logic        reg_write;
    } mem_wb_t;

    // Payload widths so each elastic stage instance can size DATA_W directly
    localparam int IF_ID_W  = $bits(if_id_t);
    localparam int ID_EX_W  = $bits(id_ex_t);
    localparam int EX_MEM_W = $bits(ex_mem_t);
    localparam int MEM_WB_W = $bits(mem_wb_t);

    // Supported range of elastic buffer depths
    localparam int ELASTIC_DEPTH_MIN = 1;
    localparam int ELASTIC_DEPTH_MAX = 4;

endpackage

// File: rtl/pipe_elastic_stage.sv
// Elastic pipeline stage: valid/ready on both sides, a DEPTH-entry circular
// buffer, synchronous flush and a saturating stall counter. in_ready and
// out_valid decode registered occupancy only, so there is no combinational
// path from the downstream ready (or flush) to any output.
module pipe_elastic_stage
    import pipelinestages_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 2,
    parameter int CNT_W  = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [DATA_W-1:0]          in_data,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [DATA_W-1:0]          out_data,
    input  logic                       flush,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic [CNT_W-1:0]           stall_cnt,
    input  logic                       stall_clr
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int OCC_W = $clog2(DEPTH + 1);
    localparam logic [PTR_W-1:0] LAST_IDX = PTR_W'(DEPTH - 1);
    localparam logic [OCC_W-1:0] FULL_CNT = OCC_W'(DEPTH);

    if (DEPTH < ELASTIC_DEPTH_MIN || DEPTH > ELASTIC_DEPTH_MAX) begin : g_depth_check
        $error("pipe_elastic_stage: DEPTH=%0d is outside the supported range 1..4", DEPTH);
    end

    logic [DATA_W-1:0] entries [DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic              push;
    logic              pop;

    // Full blocks input even when a pop happens this cycle, keeping ready registered-only
    assign in_ready  = (count < FULL_CNT);
    assign out_valid = (count != '0);
    assign out_data  = entries[rd_ptr];

    // Flush suppresses both handshakes so the flush-cycle payload is dropped
    assign push = in_valid && in_ready && !flush;
    assign pop  = out_valid && out_ready && !flush;

    // Pointers and occupancy; wrap is explicit since DEPTH may not be a power of two
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= (wr_ptr == LAST_IDX) ? '0 : wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= (rd_ptr == LAST_IDX) ? '0 : rd_ptr + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + OCC_W'(1);
                2'b01:   count <= count - OCC_W'(1);
                default: count <= count;
            endcase
        end
    end

    // Entry storage is deliberately left unreset; only occupancy marks it meaningful
    always_ff @(posedge clk) begin
        if (push) begin
            entries[wr_ptr] <= in_data;
        end
    end

    // Count cycles where the head is offered but not taken, clear wins over increment
    always_ff @(posedge clk) begin
        if (rst || stall_clr) begin
            stall_cnt <= '0;
        end else if (out_valid && !out_ready && (stall_cnt != '1)) begin
            stall_cnt <= stall_cnt + CNT_W'(1);
        end
    end

`ifndef SYNTHESIS
    a_no_push_when_full: assert property (@(posedge clk) disable iff (rst)
        !(push && (count == FULL_CNT)));

    a_no_pop_when_empty: assert property (@(posedge clk) disable iff (rst)
        !(pop && (count == '0)));

    a_count_in_range: assert property (@(posedge clk) disable iff (rst)
        (count <= FULL_CNT));
`endif

endmodule

// File: tb/tb_pipe_elastic_stage.sv
// Directed testbench for pipe_elastic_stage. Four instances cover the
// depths exercised: a (DEPTH=2, CNT_W=4), b (DEPTH=4), c (DEPTH=3), e (DEPTH=1).
module tb_pipe_elastic_stage;

    logic clk;
    logic rst;

    logic        a_in_valid, a_in_ready, a_out_valid, a_out_ready, a_flush, a_stall_clr;
    logic [31:0] a_in_data, a_out_data;
    logic [1:0]  a_count;
    logic [3:0]  a_stall_cnt;

    logic        b_in_valid, b_in_ready, b_out_valid, b_out_ready, b_flush, b_stall_clr;
    logic [31:0] b_in_data, b_out_data;
    logic [2:0]  b_count;
    logic [15:0] b_stall_cnt;

    logic        c_in_valid, c_in_ready, c_out_valid, c_out_ready, c_flush, c_stall_clr;
    logic [31:0] c_in_data, c_out_data;
    logic [1:0]  c_count;
    logic [15:0] c_stall_cnt;

    logic        e_in_valid, e_in_ready, e_out_valid, e_out_ready, e_flush, e_stall_clr;
    logic [31:0] e_in_data, e_out_data;
    logic [0:0]  e_count;
    logic [15:0] e_stall_cnt;

    int n_checks;
    int n_fail;

    pipe_elastic_stage #(.DATA_W(32), .DEPTH(2), .CNT_W(4)) u_a (
        .clk(clk), .rst(rst), .in_valid(a_in_valid), .in_ready(a_in_ready), .in_data(a_in_data),
        .out_valid(a_out_valid), .out_ready(a_out_ready), .out_data(a_out_data), .flush(a_flush),
        .count(a_count), .stall_cnt(a_stall_cnt), .stall_clr(a_stall_clr));

    pipe_elastic_stage #(.DATA_W(32), .DEPTH(4), .CNT_W(16)) u_b (
        .clk(clk), .rst(rst), .in_valid(b_in_valid), .in_ready(b_in_ready), .in_data(b_in_data),
        .out_valid(b_out_valid), .out_ready(b_out_ready), .out_data(b_out_data), .flush(b_flush),
        .count(b_count), .stall_cnt(b_stall_cnt), .stall_clr(b_stall_clr));

    pipe_elastic_stage #(.DATA_W(32), .DEPTH(3), .CNT_W(16)) u_c (
        .clk(clk), .rst(rst), .in_valid(c_in_valid), .in_ready(c_in_ready), .in_data(c_in_data),
        .out_valid(c_out_valid), .out_ready(c_out_ready), .out_data(c_out_data), .flush(c_flush),
        .count(c_count), .stall_cnt(c_stall_cnt), .stall_clr(c_stall_clr));

    pipe_elastic_stage #(.DATA_W(32), .DEPTH(1), .CNT_W(16)) u_e (
        .clk(clk), .rst(rst), .in_valid(e_in_valid), .in_ready(e_in_ready), .in_data(e_in_data),
        .out_valid(e_out_valid), .out_ready(e_out_ready), .out_data(e_out_data), .flush(e_flush),
        .count(e_count), .stall_cnt(e_stall_cnt), .stall_clr(e_stall_clr));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one clock; inputs change and outputs are sampled 1 time unit after the edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) tick();
        rst = 1'b0;
        n_checks++; if (a_out_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_out_valid: got %b want 0", a_out_valid); end
        n_checks++; if (a_in_ready !== 1'b1) begin n_fail++; $display("[TB] FAIL reset_in_ready: got %b want 1", a_in_ready); end
        n_checks++; if (a_count !== 2'd0) begin n_fail++; $display("[TB] FAIL reset_count: got %0d want 0", a_count); end
        n_checks++; if (a_stall_cnt !== 4'd0) begin n_fail++; $display("[TB] FAIL reset_stall_cnt: got %0d want 0", a_stall_cnt); end
        n_checks++; if (e_in_ready !== 1'b1) begin n_fail++; $display("[TB] FAIL reset_in_ready_d1: got %b want 1", e_in_ready); end
    endtask

    task automatic test_first_push();
        a_in_valid = 1'b1;
        a_in_data  = 32'hA5A5_0001;
        #1;
        n_checks++; if (a_out_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL no_bypass: got %b want 0", a_out_valid); end
        tick();
        a_in_valid = 1'b0;
        n_checks++; if (a_out_valid !== 1'b1) begin n_fail++; $display("[TB] FAIL first_out_valid: got %b want 1", a_out_valid); end
        n_checks++; if (a_out_data !== 32'hA5A5_0001) begin n_fail++; $display("[TB] FAIL first_out_data: got %h want a5a50001", a_out_data); end
        a_out_ready = 1'b1;
        tick();
        a_out_ready = 1'b0;
        n_checks++; if (a_count !== 2'd0) begin n_fail++; $display("[TB] FAIL first_pop_count: got %0d want 0", a_count); end
    endtask

    task automatic test_fill_order();
        b_out_ready = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            b_in_valid = 1'b1;
            b_in_data  = 32'(i);
            tick();
        end
        n_checks++; if (b_count !== 3'd4) begin n_fail++; $display("[TB] FAIL fill_count: got %0d want 4", b_count); end
        n_checks++; if (b_in_ready !== 1'b0) begin n_fail++; $display("[TB] FAIL fill_in_ready: got %b want 0", b_in_ready); end
        b_in_data = 32'h5;
        tick();
        n_checks++; if (b_count !== 3'd4) begin n_fail++; $display("[TB] FAIL fifth_rejected_count: got %0d want 4", b_count); end
        b_in_valid  = 1'b0;
        b_out_ready = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            n_checks++; if (b_out_valid !== 1'b1) begin n_fail++; $display("[TB] FAIL drain_valid_%0d: got %b want 1", i, b_out_valid); end
            n_checks++; if (b_out_data !== 32'(i)) begin n_fail++; $display("[TB] FAIL drain_data_%0d: got %h want %h", i, b_out_data, 32'(i)); end
            tick();
        end
        b_out_ready = 1'b0;
        n_checks++; if (b_out_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL drain_empty: got %b want 0", b_out_valid); end
        n_checks++; if (b_stall_cnt !== 16'd4) begin n_fail++; $display("[TB] FAIL fill_stall_cnt: got %0d want 4", b_stall_cnt); end
    endtask

    task automatic test_back_to_back();
        c_out_ready = 1'b0;
        c_in_valid  = 1'b1;
        c_in_data   = 32'h100;
        tick();
        c_out_ready = 1'b1;
        for (int k = 1; k <= 10; k++) begin
            c_in_data = 32'h100 + 32'(k);
            n_checks++; if (c_out_data !== 32'h100 + 32'(k - 1)) begin n_fail++; $display("[TB] FAIL b2b_data_%0d: got %h want %h", k, c_out_data, 32'h100 + 32'(k - 1)); end
            tick();
            n_checks++; if (c_count !== 2'd1) begin n_fail++; $display("[TB] FAIL b2b_count_%0d: got %0d want 1", k, c_count); end
        end
        c_in_valid = 1'b0;
        n_checks++; if (c_out_data !== 32'h10A) begin n_fail++; $display("[TB] FAIL b2b_last_data: got %h want 0000010a", c_out_data); end
        tick();
        c_out_ready = 1'b0;
        n_checks++; if (c_count !== 2'd0) begin n_fail++; $display("[TB] FAIL b2b_final_count: got %0d want 0", c_count); end
    endtask

    task automatic test_flush();
        b_out_ready = 1'b0;
        b_in_valid  = 1'b1;
        b_in_data   = 32'h11;
        tick();
        b_in_data   = 32'h22;
        tick();
        n_checks++; if (b_count !== 3'd2) begin n_fail++; $display("[TB] FAIL flush_setup_count: got %0d want 2", b_count); end
        b_in_data   = 32'hDEAD;
        b_flush     = 1'b1;
        b_out_ready = 1'b1;
        tick();
        b_flush    = 1'b0;
        b_in_valid = 1'b0;
        n_checks++; if (b_count !== 3'd0) begin n_fail++; $display("[TB] FAIL flush_count: got %0d want 0", b_count); end
        n_checks++; if (b_out_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL flush_out_valid: got %b want 0", b_out_valid); end
        n_checks++; if (b_in_ready !== 1'b1) begin n_fail++; $display("[TB] FAIL flush_in_ready: got %b want 1", b_in_ready); end
        n_checks++; if (b_stall_cnt !== 16'd5) begin n_fail++; $display("[TB] FAIL flush_stall_cnt: got %0d want 5", b_stall_cnt); end
        for (int i = 0; i < 3; i++) begin
            tick();
            n_checks++; if (b_out_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL flush_stays_empty_%0d: got %b want 0", i, b_out_valid); end
        end
        b_in_valid = 1'b1;
        b_in_data  = 32'h33;
        tick();
        b_in_valid = 1'b0;
        n_checks++; if (b_out_data !== 32'h33) begin n_fail++; $display("[TB] FAIL post_flush_data: got %h want 00000033", b_out_data); end
        tick();
        b_out_ready = 1'b0;
        n_checks++; if (b_count !== 3'd0) begin n_fail++; $display("[TB] FAIL post_flush_drain: got %0d want 0", b_count); end
    endtask

    task automatic test_stall_counter();
        a_out_ready = 1'b0;
        a_in_valid  = 1'b1;
        a_in_data   = 32'h55;
        tick();
        a_in_valid = 1'b0;
        repeat (20) tick();
        n_checks++; if (a_stall_cnt !== 4'd15) begin n_fail++; $display("[TB] FAIL stall_saturate: got %0d want 15", a_stall_cnt); end
        a_stall_clr = 1'b1;
        tick();
        a_stall_clr = 1'b0;
        n_checks++; if (a_stall_cnt !== 4'd0) begin n_fail++; $display("[TB] FAIL stall_clr_wins: got %0d want 0", a_stall_cnt); end
        tick();
        n_checks++; if (a_stall_cnt !== 4'd1) begin n_fail++; $display("[TB] FAIL stall_resume: got %0d want 1", a_stall_cnt); end
        a_out_ready = 1'b1;
        tick();
        a_out_ready = 1'b0;
        n_checks++; if (a_stall_cnt !== 4'd1) begin n_fail++; $display("[TB] FAIL stall_hold_on_pop: got %0d want 1", a_stall_cnt); end
        n_checks++; if (a_count !== 2'd0) begin n_fail++; $display("[TB] FAIL stall_final_count: got %0d want 0", a_count); end
    endtask

    task automatic test_depth1();
        int accepted;
        accepted    = 0;
        e_out_ready = 1'b1;
        e_in_valid  = 1'b1;
        for (int k = 0; k < 8; k++) begin
            e_in_data = 32'h1000 + 32'(accepted);
            n_checks++; if (e_in_ready !== (k % 2 == 0)) begin n_fail++; $display("[TB] FAIL d1_in_ready_%0d: got %b want %b", k, e_in_ready, (k % 2 == 0)); end
            n_checks++; if (e_out_valid !== (k % 2 == 1)) begin n_fail++; $display("[TB] FAIL d1_out_valid_%0d: got %b want %b", k, e_out_valid, (k % 2 == 1)); end
            if (k % 2 == 1) begin
                n_checks++; if (e_out_data !== 32'h1000 + 32'((k - 1) / 2)) begin n_fail++; $display("[TB] FAIL d1_data_%0d: got %h want %h", k, e_out_data, 32'h1000 + 32'((k - 1) / 2)); end
            end
            if (k % 2 == 0) accepted++;
            tick();
        end
        e_in_data = 32'h2000;
        tick();
        n_checks++; if (e_out_valid !== 1'b1) begin n_fail++; $display("[TB] FAIL d1_pre_reset_valid: got %b want 1", e_out_valid); end
        rst = 1'b1;
        tick();
        rst        = 1'b0;
        e_in_valid = 1'b0;
        n_checks++; if (e_out_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL d1_reset_out_valid: got %b want 0", e_out_valid); end
        n_checks++; if (e_in_ready !== 1'b1) begin n_fail++; $display("[TB] FAIL d1_reset_in_ready: got %b want 1", e_in_ready); end
        n_checks++; if (e_count !== 1'd0) begin n_fail++; $display("[TB] FAIL d1_reset_count: got %0d want 0", e_count); end
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst = 1'b1;
        a_in_valid = 1'b0; a_out_ready = 1'b0; a_flush = 1'b0; a_stall_clr = 1'b0; a_in_data = '0;
        b_in_valid = 1'b0; b_out_ready = 1'b0; b_flush = 1'b0; b_stall_clr = 1'b0; b_in_data = '0;
        c_in_valid = 1'b0; c_out_ready = 1'b0; c_flush = 1'b0; c_stall_clr = 1'b0; c_in_data = '0;
        e_in_valid = 1'b0; e_out_ready = 1'b0; e_flush = 1'b0; e_stall_clr = 1'b0; e_in_data = '0;
        #1;

        $display("[TB] starting directed tests");
        test_reset();
        test_first_push();
        test_fill_order();
        test_back_to_back();
        test_flush();
        test_stall_counter();
        test_depth1();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/pipe_elastic_stage.md
# pipe_elastic_stage

Parametrised elastic pipeline stage for the RISC pipeline. It replaces the plain IF/ID, ID/EX, EX/MEM and MEM/WB struct registers with one reusable block. The block has a valid/ready handshake on both sides, a small circular buffer of DEPTH entries, synchronous flush, and a saturating stall counter. The payload is opaque: the instantiating stage packs its stage struct into DATA_W bits.

## Interface
Parameters:
- DATA_W, 32: payload width in bits. Set per instance to the `$bits` of the stage struct.
- DEPTH, 2: number of buffer entries. Legal range 1..4; other values are rejected by an elaboration assertion.
- CNT_W, 16: width of the stall counter.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  upstream presents a payload.
- in_ready  out  1  stage can accept a payload this cycle.
- in_data  in  DATA_W  upstream payload.
- out_valid  out  1  head entry is valid.
- out_ready  in  1  downstream accepts the head this cycle.
- out_data  out  DATA_W  head entry payload.
- flush  in  1  discard all held entries and any incoming payload (branch mispredict or redirect).
- count  out  $clog2(DEPTH+1)  number of occupied entries.
- stall_cnt  out  CNT_W  number of cycles with out_valid=1 and out_ready=0; saturates at all-ones.
- stall_clr  in  1  clears stall_cnt.

## Operation
Handshake events:
- Push occurs when in_valid && in_ready && !flush.
- Pop occurs when out_valid && out_ready && !flush.
- in_ready = (count < DEPTH). It is a pure function of registered state; there is no combinational path from out_ready to in_ready.
- out_valid = (count != 0).
- out_data = entry[rd_ptr]. It is don't-care while out_valid=0.

Buffer behaviour:
- Pointers wrap modulo DEPTH; the wrap is explicit, because DEPTH need not be a power of two.
- A push and a pop in the same cycle leave count unchanged. Both pointers advance.
- When full, in_ready=0 even if a pop occurs that cycle; a push cannot ride on the pop.
- When empty there is no bypass: an input pushed in cycle N appears at out_valid no earlier than N+1.

Flush:
- Flush takes priority over push and pop.
- On the next edge: count=0, wr_ptr=rd_ptr=0. The in_data offered in the flush cycle is dropped.
- stall_cnt is not affected by flush.

Stall counter:
- Increments each cycle where out_valid && !out_ready, saturating at all-ones.
- stall_clr takes priority over increment. A simultaneous clr and stall yields 0.

Reset:
- Reset sets count=0, pointers=0 and stall_cnt=0.
- Output values after reset: out_valid=0, in_ready=1, count=0, stall_cnt=0.
- Entry storage is not reset.
- Reset asserted mid-transfer behaves exactly like a flush plus a counter clear.

## Timing
- Latency is 1 cycle from an accepted push to out_valid when the buffer is empty.
- Throughput is 1 payload per cycle with DEPTH≥2 under a continuous out_ready.
- With DEPTH=1 and continuous traffic, throughput is 1 payload every 2 cycles, because in_ready depends only on count.
- The flush in cycle N produces out_valid=0 and in_ready=1 in cycle N+1.
- count, in_ready and out_valid all change only on clock edges.
- Every output is either registered or a decode of registered state only; no output depends combinationally on in_valid, out_ready or flush.

## Structure
- Shared package: keep the existing stage structs in pipelinestages_pkg. Add localparams IF_ID_W, ID_EX_W, EX_MEM_W and MEM_WB_W (the `$bits` of each struct) so instances set DATA_W without magic numbers.
- No sub-module. Pointer, count and stall logic stay inline in pipe_elastic_stage. The entry array is an unpacked array of DATA_W registers.
- Assertions (simulation only):
  - no push while count==DEPTH;
  - no pop while count==0;
  - count ≤ DEPTH.

## Test plan
- Reset, then idle, DEPTH=2:
  - out_valid=0, in_ready=1, count=0, stall_cnt=0.
  - Push 0xA5A5_0001 → out_valid=1 next cycle with out_data=0xA5A5_0001.
- Fill and order, DEPTH=4, out_ready=0:
  - Push 0x1, 0x2, 0x3, 0x4 → count=4 and in_ready=0. A fifth in_valid is not accepted.
  - Raise out_ready → pops 0x1..0x4 in order, one per cycle.
- Simultaneous push/pop at count=1: count stays 1, and data order is preserved across pointer wrap (>DEPTH transfers, e.g. 10 words, DEPTH=3).
- Flush with count=2 while in_valid=1 (data 0xDEAD):
  - Next cycle: count=0, out_valid=0.
  - 0xDEAD never appears at out_data.
  - stall_cnt unchanged.
- Stall counter, CNT_W=4:
  - Hold out_valid=1 and out_ready=0 for 20 cycles → stall_cnt=15 (saturated).
  - Assert stall_clr together with the stall → 0.
- DEPTH=1:
  - With continuous in_valid and out_ready → accepts every other cycle.
  - Mid-stream rst → out_valid=0 and in_ready=1 next cycle.
